// File: rtl/data_mem_responder_if.sv
// Load/store bus between a CPU data port and data_mem_responder.
// ReadData is combinational from Addr; all other signals are driven by the master.
interface data_mem_responder_if;
    logic        MemWrite;
    logic [3:0]  byteEnable;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (
        output MemWrite,
        output byteEnable,
        output Addr,
        output WriteData,
        input  ReadData
    );

    modport slave (
        input  MemWrite,
        input  byteEnable,
        input  Addr,
        input  WriteData,
        output ReadData
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-side responder: zero-latency word RAM at 0x0xxx_xxxx plus an MMIO block at 0xF000_0000.
// Define DMEM_TIMER_EN to build the CNT/CMP timer and MatchIrq; otherwise those registers read 0.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus,
    output logic [7:0]           Leds,
    output logic                 MatchIrq,
    output logic                 AccessErr
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        REG_CNT  = 2'd0,
        REG_LED  = 2'd1,
        REG_CMP  = 2'd2,
        REG_STAT = 2'd3
    } mmio_reg_e;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    logic [27:0]   ram_hi;
    logic          sel_ram;
    logic          sel_mmio;
    logic          aligned;
    logic          ram_hit;
    logic          mmio_hit;
    logic          bad_access;
    logic          wr_en;
    logic          ram_we;
    logic          mmio_we;
    logic          stat_clr;
    logic          clr_err;
    mmio_reg_e     mmio_sel;
    logic [AW-1:0] ram_idx;

    // A RAM address is mapped only when every bit above the word index is zero.
    assign ram_hi     = bus.Addr[27:0] >> (AW + 2);
    assign sel_ram    = (bus.Addr[31:28] == 4'h0) && (ram_hi == '0);
    assign sel_mmio   = (bus.Addr[31:28] == 4'hF) && (bus.Addr[27:4] == '0);
    assign aligned    = (bus.Addr[1:0] == 2'b00);
    assign ram_hit    = sel_ram && aligned;
    assign mmio_hit   = sel_mmio && aligned;
    assign bad_access = !(ram_hit || mmio_hit);
    assign mmio_sel   = mmio_reg_e'(bus.Addr[3:2]);
    assign ram_idx    = bus.Addr[AW+1:2];

    assign wr_en    = bus.MemWrite && !reset;
    assign ram_we   = wr_en && ram_hit;
    assign mmio_we  = wr_en && mmio_hit;
    assign stat_clr = mmio_we && (mmio_sel == REG_STAT) && bus.byteEnable[0];
    assign clr_err  = stat_clr && bus.WriteData[1];

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: RAM has no reset; a reset loop over every word would block RAM inference.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.byteEnable[i]) mem[ram_idx][8*i +: 8] <= bus.WriteData[8*i +: 8];
            end
        end
    end

    logic [7:0] led_q, led_d;
    logic       err_q, err_d;

    always_comb begin
        led_d = led_q;
        if (mmio_we && (mmio_sel == REG_LED) && bus.byteEnable[0]) led_d = bus.WriteData[7:0];
        // Set wins over a same-cycle write-1-to-clear.
        err_d = bad_access ? 1'b1 : (clr_err ? 1'b0 : err_q);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q <= '0;
            err_q <= 1'b0;
        end else begin
            led_q <= led_d;
            err_q <= err_d;
        end
    end

    logic [31:0] cnt_rd;
    logic [31:0] cmp_rd;
    logic        irq;

`ifdef DMEM_TIMER_EN
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] cmp_q, cmp_d;
    logic        irq_q, irq_d;
    logic        clr_irq;

    assign clr_irq = stat_clr && bus.WriteData[0];

    always_comb begin
        cnt_d = cnt_q + 32'd1;
        cmp_d = cmp_q;
        if (mmio_we && (mmio_sel == REG_CNT)) cnt_d = merge_lanes(cnt_q, bus.WriteData, bus.byteEnable);
        if (mmio_we && (mmio_sel == REG_CMP)) cmp_d = merge_lanes(cmp_q, bus.WriteData, bus.byteEnable);
        irq_d = (cnt_q == cmp_q) ? 1'b1 : (clr_irq ? 1'b0 : irq_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            cmp_q <= 32'hFFFF_FFFF;
            irq_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            cmp_q <= cmp_d;
            irq_q <= irq_d;
        end
    end

    assign cnt_rd = cnt_q;
    assign cmp_rd = cmp_q;
    assign irq    = irq_q;
`else
    assign cnt_rd = '0;
    assign cmp_rd = '0;
    assign irq    = 1'b0;
`endif

    // NOTE: the read mux assigns a default first so no path can infer a latch.
    always_comb begin
        bus.ReadData = '0;
        if (ram_hit) begin
            bus.ReadData = mem[ram_idx];
        end else if (mmio_hit) begin
            unique case (mmio_sel)
                REG_CNT:  bus.ReadData = cnt_rd;
                REG_LED:  bus.ReadData = {24'h0, led_q};
                REG_CMP:  bus.ReadData = cmp_rd;
                REG_STAT: bus.ReadData = {30'h0, err_q, irq};
                default:  bus.ReadData = '0;
            endcase
        end
    end

    assign Leds      = led_q;
    assign MatchIrq  = irq;
    assign AccessErr = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: RAM vector table, then timer, bad-access and reset sequences.
// Expectations follow DMEM_TIMER_EN the same way the design build does.
module tb_data_mem_responder;

    localparam logic [31:0] A_CNT  = 32'hF000_0000;
    localparam logic [31:0] A_LED  = 32'hF000_0004;
    localparam logic [31:0] A_CMP  = 32'hF000_0008;
    localparam logic [31:0] A_STAT = 32'hF000_000C;

`ifdef DMEM_TIMER_EN
    localparam bit TIMER = 1'b1;
    localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;
`else
    localparam bit TIMER = 1'b0;
    localparam logic [31:0] CMP_RST = 32'h0;
`endif

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp_rd;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] leds;
    logic match_irq;
    logic access_err;

    int checks = 0;
    int errors = 0;

    data_mem_responder_if bus_if ();

    data_mem_responder #(.DEPTH_WORDS(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .Leds      (leds),
        .MatchIrq  (match_irq),
        .AccessErr (access_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one access for the next cycle; returns 1 time unit after the falling edge.
    task automatic bus(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.MemWrite   = we;
        bus_if.byteEnable = be;
        bus_if.Addr       = a;
        bus_if.WriteData  = d;
        #1;
    endtask

    vec_t vecs [20];

    initial begin
        bus_if.MemWrite   = 1'b0;
        bus_if.byteEnable = 4'h0;
        bus_if.Addr       = A_CNT;
        bus_if.WriteData  = '0;

        vecs[0]  = '{1'b1, 4'hF, 32'h10, 32'hAABB_CCDD, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 4'h5, 32'h10, 32'h1122_3344, 1'b1, 32'hAABB_CCDD};
        vecs[2]  = '{1'b0, 4'h0, 32'h10, 32'h0,         1'b1, 32'hAA22_CC44};
        vecs[3]  = '{1'b1, 4'hF, 32'h14, 32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 4'h0, 32'h14, 32'h0,         1'b1, 32'hCAFE_F00D};
        vecs[5]  = '{1'b0, 4'h0, 32'h14, 32'h0,         1'b1, 32'hCAFE_F00D};
        vecs[6]  = '{1'b1, 4'hF, 32'h20, 32'h9,         1'b0, 32'h0};
        vecs[7]  = '{1'b1, 4'hF, 32'h20, 32'h5,         1'b1, 32'h9};
        vecs[8]  = '{1'b0, 4'h0, 32'h20, 32'h0,         1'b1, 32'h5};
        vecs[9]  = '{1'b1, 4'h2, 32'h20, 32'h0000_AB00, 1'b1, 32'h5};
        vecs[10] = '{1'b0, 4'h0, 32'h20, 32'h0,         1'b1, 32'h0000_AB05};
        vecs[11] = '{1'b1, 4'hF, 32'h00, 32'h1234_5678, 1'b0, 32'h0};
        vecs[12] = '{1'b0, 4'h0, 32'h00, 32'h0,         1'b1, 32'h1234_5678};
        vecs[13] = '{1'b1, 4'hF, A_LED,  32'h0000_01A5, 1'b1, 32'h0};
        vecs[14] = '{1'b0, 4'h0, A_LED,  32'h0,         1'b1, 32'hA5};
        vecs[15] = '{1'b1, 4'h0, A_LED,  32'hFFFF_FFFF, 1'b1, 32'hA5};
        vecs[16] = '{1'b0, 4'h0, A_LED,  32'h0,         1'b1, 32'hA5};
        vecs[17] = '{1'b1, 4'hF, 32'hFC, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[18] = '{1'b0, 4'h0, 32'hFC, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[19] = '{1'b0, 4'h0, 32'h10, 32'h0,         1'b1, 32'hAA22_CC44};

        // Reset state.
        @(negedge clk);
        #1;
        check("rst_cnt", bus_if.ReadData, 32'h0);
        check("rst_leds", {24'h0, leds}, 32'h0);
        check("rst_irq", {31'h0, match_irq}, 32'h0);
        check("rst_err", {31'h0, access_err}, 32'h0);
        bus_if.Addr = A_CMP;
        #1;
        check("rst_cmp", bus_if.ReadData, CMP_RST);
        bus_if.Addr = A_CNT;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("cnt_held_at_release", bus_if.ReadData, 32'h0);
        bus(1'b0, 4'h0, A_CNT, 32'h0);
        check("cnt_first_edge", bus_if.ReadData, TIMER ? 32'h1 : 32'h0);
        bus(1'b0, 4'h0, A_CNT, 32'h0);
        check("cnt_second_edge", bus_if.ReadData, TIMER ? 32'h2 : 32'h0);

        // RAM and LED vector table.
        for (int i = 0; i < 20; i++) begin
            bus(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].chk) check($sformatf("vec%0d_rd", i), bus_if.ReadData, vecs[i].exp_rd);
        end
        check("leds_after_table", {24'h0, leds}, 32'hA5);
        check("err_after_table", {31'h0, access_err}, 32'h0);

        // Bad accesses.
        bus(1'b0, 4'h0, 32'h0000_0003, 32'h0);
        check("misaligned_rd", bus_if.ReadData, 32'h0);
        bus(1'b1, 4'hF, 32'h5000_0000, 32'hFFFF_FFFF);
        check("err_set", {31'h0, access_err}, 32'h1);
        check("unmapped_rd", bus_if.ReadData, 32'h0);
        bus(1'b1, 4'hF, 32'h0000_0100, 32'h0);
        check("ram_range_rd", bus_if.ReadData, 32'h0);
        bus(1'b1, 4'hF, 32'h0000_0012, 32'h0);
        bus(1'b0, 4'h0, 32'hF000_0010, 32'h0);
        check("mmio_range_rd", bus_if.ReadData, 32'h0);
        bus(1'b0, 4'h0, 32'h00, 32'h0);
        check("word0_intact", bus_if.ReadData, 32'h1234_5678);
        bus(1'b0, 4'h0, 32'h10, 32'h0);
        check("word4_intact", bus_if.ReadData, 32'hAA22_CC44);
        bus(1'b0, 4'h0, A_STAT, 32'h0);
        check("stat_err_rd", bus_if.ReadData, 32'h2);
        bus(1'b1, 4'hE, A_STAT, 32'h2);
        bus(1'b0, 4'h0, A_STAT, 32'h0);
        check("stat_clr_needs_be0", bus_if.ReadData, 32'h2);
        bus(1'b1, 4'hF, A_STAT, 32'h2);
        bus(1'b0, 4'h0, A_STAT, 32'h0);
        check("err_cleared", {31'h0, access_err}, 32'h0);
        check("stat_after_clr", bus_if.ReadData, 32'h0);

        // Timer wrap, match and clear.
        if (TIMER) begin
            bus(1'b1, 4'hF, A_CMP, 32'h1);
            bus(1'b1, 4'hF, A_CNT, 32'hFFFF_FFFE);
            bus(1'b0, 4'h0, A_CNT, 32'h0);
            check("cnt_written", bus_if.ReadData, 32'hFFFF_FFFE);
            bus(1'b0, 4'h0, A_CNT, 32'h0);
            check("cnt_max", bus_if.ReadData, 32'hFFFF_FFFF);
            bus(1'b0, 4'h0, A_CNT, 32'h0);
            check("cnt_wrap", bus_if.ReadData, 32'h0);
            bus(1'b0, 4'h0, A_CNT, 32'h0);
            check("cnt_one", bus_if.ReadData, 32'h1);
            check("irq_not_yet", {31'h0, match_irq}, 32'h0);
            bus(1'b0, 4'h0, A_STAT, 32'h0);
            check("irq_set", {31'h0, match_irq}, 32'h1);
            check("stat_irq_rd", bus_if.ReadData, 32'h1);
            bus(1'b1, 4'hE, A_STAT, 32'h1);
            bus(1'b0, 4'h0, A_STAT, 32'h0);
            check("irq_clr_needs_be0", {31'h0, match_irq}, 32'h1);
            bus(1'b1, 4'hF, A_STAT, 32'h1);
            bus(1'b0, 4'h0, A_STAT, 32'h0);
            check("irq_cleared", {31'h0, match_irq}, 32'h0);
            check("stat_irq_clr_rd", bus_if.ReadData, 32'h0);

            // Clear during a CNT==CMP cycle: the set must win.
            bus(1'b1, 4'hF, A_CMP, 32'h100);
            bus(1'b1, 4'hF, A_CNT, 32'h100);
            bus(1'b1, 4'hF, A_CNT, 32'h100);
            check("prio_irq_before", {31'h0, match_irq}, 32'h0);
            bus(1'b1, 4'h1, A_STAT, 32'h1);
            check("prio_irq_set", {31'h0, match_irq}, 32'h1);
            bus(1'b0, 4'h0, 32'h0, 32'h0);
            check("prio_irq_kept", {31'h0, match_irq}, 32'h1);
            bus(1'b1, 4'h1, A_STAT, 32'h1);
            bus(1'b0, 4'h0, 32'h0, 32'h0);
            check("prio_irq_cleared", {31'h0, match_irq}, 32'h0);
        end else begin
            bus(1'b1, 4'hF, A_CNT, 32'h1234_5678);
            bus(1'b1, 4'hF, A_CMP, 32'h1);
            bus(1'b0, 4'h0, A_CNT, 32'h0);
            check("notimer_cnt_rd", bus_if.ReadData, 32'h0);
            check("notimer_no_err", {31'h0, access_err}, 32'h0);
            bus(1'b0, 4'h0, A_CMP, 32'h0);
            check("notimer_cmp_rd", bus_if.ReadData, 32'h0);
            bus(1'b0, 4'h0, A_STAT, 32'h0);
            check("notimer_stat_rd", bus_if.ReadData, 32'h0);
            check("notimer_irq", {31'h0, match_irq}, 32'h0);
        end

        // Mid-count reset with both flags pending.
        bus(1'b1, 4'hF, A_CNT, 32'h100);
        bus(1'b0, 4'h0, 32'h0000_0003, 32'h0);
        bus(1'b0, 4'h0, A_CNT, 32'h0);
        check("pre_rst_cnt", bus_if.ReadData, TIMER ? 32'h101 : 32'h0);
        check("pre_rst_irq", {31'h0, match_irq}, TIMER ? 32'h1 : 32'h0);
        check("pre_rst_err", {31'h0, access_err}, 32'h1);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_leds", {24'h0, leds}, 32'h0);
        check("mid_rst_cnt", bus_if.ReadData, 32'h0);
        check("mid_rst_irq", {31'h0, match_irq}, 32'h0);
        check("mid_rst_err", {31'h0, access_err}, 32'h0);
        bus_if.Addr = A_CMP;
        #1;
        check("mid_rst_cmp", bus_if.ReadData, CMP_RST);
        bus(1'b1, 4'hF, 32'h10, 32'h0);
        bus(1'b1, 4'hF, A_LED, 32'hFF);
        bus(1'b0, 4'h0, 32'h10, 32'h0);
        check("rst_blocks_ram_wr", bus_if.ReadData, 32'hAA22_CC44);
        check("rst_blocks_led_wr", {24'h0, leds}, 32'h0);
        bus_if.Addr = A_CNT;
        #1;
        check("rst_cnt_held", bus_if.ReadData, 32'h0);
        bus(1'b0, 4'h0, A_CNT, 32'h0);
        reset = 1'b0;
        bus(1'b0, 4'h0, A_CNT, 32'h0);
        check("post_rst_cnt1", bus_if.ReadData, TIMER ? 32'h1 : 32'h0);
        bus(1'b0, 4'h0, A_CNT, 32'h0);
        check("post_rst_cnt2", bus_if.ReadData, TIMER ? 32'h2 : 32'h0);
        check("post_rst_irq", {31'h0, match_irq}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, giving the number of 32-bit RAM words; must be a power of two and at most 2^26.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, with all state updating on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port MemWrite, input, 1 bit: write strobe for the current access.
REQ-005 SHALL have port byteEnable, input, 4 bits: per-byte write lanes, where bit i selects WriteData[8i+7:8i].
REQ-006 SHALL have port Addr, input, 32 bits: byte address.
REQ-007 SHALL have port WriteData, input, 32 bits: store data.
REQ-008 SHALL have port ReadData, output, 32 bits: load data.
REQ-009 SHALL have port Leds, output, 8 bits: LED register value.
REQ-010 SHALL have port MatchIrq, output, 1 bit: sticky timer-match flag.
REQ-011 SHALL have port AccessErr, output, 1 bit: sticky bad-access flag.

Function
REQ-012 SHALL decode Addr[31:28]=4'h0 as RAM, Addr[31:28]=4'hF with Addr[27:4]=0 as MMIO, and every other address as unmapped.
REQ-013 SHALL index RAM by Addr[log2(DEPTH_WORDS)+1:2]; a RAM address with any nonzero bit in Addr[27:log2(DEPTH_WORDS)+2] is unmapped.
REQ-014 SHALL drive ReadData combinationally from the current Addr (zero latency), so the value is valid within the same cycle the load is presented.
REQ-015 SHALL perform writes at the clock edge and update only the lanes whose byteEnable bit is 1; MemWrite=1 with byteEnable=4'b0000 leaves all state unchanged.
REQ-016 SHALL show the old data on ReadData during a write cycle when the read and write target the same word, and the new data from the following cycle on.
REQ-017 SHALL map MMIO word 0xF000_0000 as CNT: a 32-bit free-running counter that increments every cycle and wraps from 0xFFFF_FFFF to 0.
REQ-018 SHALL map MMIO word 0xF000_0004 as LED: bits [7:0] are read/write and drive Leds, and bits [31:8] read as 0.
REQ-019 SHALL map MMIO word 0xF000_0008 as CMP: a 32-bit read/write compare value.
REQ-020 SHALL map MMIO word 0xF000_000C as STAT: bit0 is MatchIrq and bit1 is AccessErr, both write-1-to-clear and honoring byteEnable[0], with bits [31:2] reading as 0.
REQ-021 SHALL write CNT with byte-lane merging when software writes it; the write overrides that cycle's increment and counting resumes from the written value on the next cycle.
REQ-022 SHALL set MatchIrq at the edge after any cycle in which CNT==CMP.
REQ-023 SHALL give the set priority when a MatchIrq set and a STAT clear occur in the same cycle.
REQ-024 SHALL return 0 on ReadData for an unmapped access or a misaligned access (Addr[1:0]!=0).
REQ-025 SHALL ignore writes to unmapped or misaligned addresses, and SHALL set AccessErr at the next edge for any such access, read or write.
REQ-026 SHALL give the set priority when an AccessErr set and a STAT clear occur in the same cycle.

Reset
REQ-027 SHALL, while reset=1, immediately force CNT=0, CMP=0xFFFF_FFFF, LED=0, MatchIrq=0 and AccessErr=0, independent of clk.
REQ-028 SHALL not reset RAM contents, and RAM reads before the first write are undefined.
REQ-029 SHALL ignore writes while reset=1, and SHALL have the counter increment on the first rising edge after reset deasserts.
REQ-030 SHALL, when reset asserts mid-count, discard CNT and the pending flags with no residual state.

Configuration
REQ-031 SHALL, when macro DMEM_TIMER_EN is defined, implement CNT, CMP and MatchIrq as specified above.
REQ-032 SHALL, when DMEM_TIMER_EN is undefined, build no counter or compare logic; CNT and CMP read 0, writes to them are accepted and ignored without setting AccessErr, MatchIrq ties to 0, and STAT bit0 reads 0.

Verification
REQ-033 SHALL cover byte-lane writes: write 0xAABBCCDD to 0x10 with be=4'b1111, then write 0x11223344 with be=4'b0101 -> read 0x10 returns 0xAA22CC44.
REQ-034 SHALL cover read-during-write: write 0x5 to 0x20 while reading 0x20 -> ReadData shows the old value that cycle and 0x5 the next cycle.
REQ-035 SHALL cover counter wrap and match: write CNT=0xFFFF_FFFE and CMP=0x1 -> CNT reads 0 two cycles later and MatchIrq=1 one cycle after CNT==1; then write STAT=0x1 -> MatchIrq=0.
REQ-036 SHALL cover bad accesses: read 0x0000_0003, then write 0x5000_0000 -> ReadData=0 on the read, RAM unchanged, AccessErr=1; then write STAT=0x2 -> AccessErr=0.
REQ-037 SHALL cover LED and reset: write LED=0x1A5 -> Leds=0xA5 and read returns 0xA5; then assert reset between clock edges -> Leds=0 and CNT=0 immediately.
REQ-038 SHALL cover set-versus-clear priority: a STAT clear in the same cycle CNT==CMP -> MatchIrq remains 1.
